// File: rtl/aes256_key_sched_ctrl_pkg.sv
// Shared AES-256 key-schedule definitions: S-box, round constants, sizes and FSM state.
package aes_pkg;

  localparam int NUM_RK    = 15;
  localparam int NUM_STEPS = 7;
  localparam logic [2:0] LAST_CNT = 3'(NUM_STEPS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  // Entry 0 is never used; steps count 1..7.
  localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                      8'h08, 8'h10, 8'h20, 8'h40};

  // Byte n of the table sits at bits [8n +: 8], MSB first.
  localparam logic [0:2047] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_ROM[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes256_key_sched_ctrl_if.sv
// Key-load / round-key-read bus between the key scheduler and its client.
interface aes256_key_sched_ctrl_if;
  logic           iStart;
  logic [0:255]   iKey;
  logic           iClear;
  logic [3:0]     iRk_Idx;
  logic [0:127]   oRound_Key;
  logic           oBusy;
  logic           oDone;
  logic           oKey_Valid;

  modport master (
    output iStart, iKey, iClear, iRk_Idx,
    input  oRound_Key, oBusy, oDone, oKey_Valid
  );

  modport slave (
    input  iStart, iKey, iClear, iRk_Idx,
    output oRound_Key, oBusy, oDone, oKey_Valid
  );
endinterface

// File: rtl/aes256_key_step.sv
// One AES-256 key-expansion step: eight old words in, eight new words out (8 S-boxes).
module aes256_key_step
  import aes_pkg::*;
(
  input  logic [0:255] w_i,
  input  logic [2:0]   cnt_i,
  output logic [0:255] w_o
);

  logic [31:0] ow [8];
  logic [31:0] nw [8];

  // NOTE: every combinational output is assigned on all paths so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 8; i++) ow[i] = w_i[32*i +: 32];

    nw[0] = ow[0] ^ sub_word(rot_word(ow[7])) ^ {RCON[cnt_i], 24'h0};
    nw[1] = nw[0] ^ ow[1];
    nw[2] = nw[1] ^ ow[2];
    nw[3] = nw[2] ^ ow[3];
    nw[4] = ow[4] ^ sub_word(nw[3]);
    nw[5] = nw[4] ^ ow[5];
    nw[6] = nw[5] ^ ow[6];
    nw[7] = nw[6] ^ ow[7];

    w_o = '0;
    for (int i = 0; i < 8; i++) w_o[32*i +: 32] = nw[i];
  end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Iterative AES-256 key scheduler: seven shared expansion steps fill a 15-entry round-key file.
module aes256_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter bit REG_READ = 1'b1
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  aes256_key_sched_ctrl_if.slave  bus
);

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [0:255] w_q, w_d, w_next;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic [0:127] rk_q [NUM_RK];
  logic [0:127] rd_data;

  logic         busy;
  logic         start_go;
  logic         step_go;
  logic         last_step;
  logic [3:0]   idx_even, idx_odd;

  aes256_key_step u_step (
    .w_i   (w_q),
    .cnt_i (cnt_q),
    .w_o   (w_next)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // A clear always wins, both over a pending start and over an expansion in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.iStart && !bus.iClear) state_d = ST_EXPAND;
      ST_EXPAND: if (bus.iClear || cnt_q == LAST_CNT) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    start_go = 1'b0;
    step_go  = 1'b0;
    unique case (state_q)
      ST_IDLE:   start_go = bus.iStart && !bus.iClear;
      ST_EXPAND: begin
        busy    = 1'b1;
        step_go = !bus.iClear;
      end
      default: ;
    endcase
  end

  assign last_step = step_go && (cnt_q == LAST_CNT);
  assign idx_even  = {cnt_q, 1'b0};
  assign idx_odd   = {cnt_q, 1'b1};

  always_comb begin
    cnt_d   = cnt_q;
    w_d     = w_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    if (start_go) begin
      w_d     = bus.iKey;
      cnt_d   = 3'd1;
      valid_d = 1'b0;
    end else if (step_go) begin
      w_d   = w_next;
      cnt_d = cnt_q + 3'd1;
      if (last_step) begin
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
    end else if (bus.iClear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q   <= '0;
      w_q     <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the key file is reset on purpose; a read after reset must return zeros.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else if (start_go) begin
      rk_q[0] <= bus.iKey[0:127];
      rk_q[1] <= bus.iKey[128:255];
    end else if (step_go) begin
      rk_q[idx_even] <= w_next[0:127];
      // The final step only yields RK14; its upper half has no slot.
      if (cnt_q != LAST_CNT) rk_q[idx_odd] <= w_next[128:255];
    end
  end

  assign rd_data = (bus.iRk_Idx < 4'(NUM_RK)) ? rk_q[bus.iRk_Idx] : '0;

  generate
    if (REG_READ) begin : g_reg_read
      logic [0:127] rd_q;
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) rd_q <= '0;
        else         rd_q <= rd_data;
      end
      assign bus.oRound_Key = rd_q;
    end else begin : g_comb_read
      assign bus.oRound_Key = rd_data;
    end
  endgenerate

  assign bus.oBusy      = busy;
  assign bus.oDone      = done_q;
  assign bus.oKey_Valid = valid_q;

endmodule

// File: doc/aes256_key_sched_ctrl.md
# aes256_key_sched_ctrl

Iterative AES-256 key-schedule controller. It sequences one shared combinational key-expansion step over seven iterations instead of seven unrolled stages. It writes all 15 round keys into an internal register file and serves them to the cipher round logic through an indexed read port. It sits between key load and the encrypt/decrypt round datapath.

## Interface
- REG_READ, default 1: 1 = read port registered (1-cycle latency); 0 = combinational read.
- iClk  in  1  Clock; all state updates on the rising edge.
- iRst_n  in  1  Reset; asynchronous, active-low.
- iStart  in  1  Start pulse; samples iKey; honoured only in IDLE.
- iKey  in  [0:255]  Cipher key; bit 0 = MSB of word w0.
- iClear  in  1  Synchronous invalidate of stored keys.
- iRk_Idx  in  [3:0]  Round-key index, 0..14.
- oRound_Key  out  [0:127]  Round key selected by iRk_Idx.
- oBusy  out  1  High while expansion is in progress.
- oDone  out  1  One-cycle pulse when expansion completes.
- oKey_Valid  out  1  Level; all 15 round keys are stored and consistent.

## Operation
- States: IDLE, EXPAND.
  - IDLE -> EXPAND on iStart.
  - EXPAND -> IDLE when step count cnt == 7.
- Work register W[0:255] holds the previous 8 words. Step counter cnt is 3 bits, range 1..7.
- Start edge (IDLE, iStart=1):
  - W <= iKey; RK0 <= iKey[0:127]; RK1 <= iKey[128:255].
  - cnt <= 1; oBusy <= 1; oKey_Valid <= 0.
- Each EXPAND edge: W' = step(W, cnt); W <= W'.
  - cnt 1..6: RK[2cnt] <= W'[0:127] and RK[2cnt+1] <= W'[128:255].
  - cnt 7: only RK14 <= W'[0:127]; the upper half is discarded.
- step(W, c), with w[i] the new words:
  - w8 = w0 ^ SubWord(RotWord(w7)) ^ {RCON[c],24'h0}.
  - w9..w11: each word = its predecessor in the new block ^ the corresponding old word.
  - w12 = w4 ^ SubWord(w11).
  - w13..w15: chained the same way as w9..w11.
  - RCON[1..7] = 01, 02, 04, 08, 10, 20, 40 (hex).
- Completion edge (cnt == 7): state <= IDLE, oBusy <= 0, oDone <= 1 for one cycle, oKey_Valid <= 1.
- iStart while EXPAND is ignored. iKey is not re-sampled.
- iStart in IDLE with oKey_Valid=1 restarts expansion. oKey_Valid drops at the start edge.
- iClear:
  - In IDLE: oKey_Valid <= 0; RK contents are kept.
  - In EXPAND: abort; state <= IDLE, oBusy <= 0, no oDone, oKey_Valid stays 0.
- iClear and iStart in the same cycle: iClear wins and the start is dropped.
- Read port:
  - iRk_Idx 15 returns all zeros.
  - A read during EXPAND returns whatever is currently stored. Data is guaranteed only when oKey_Valid=1.
- Reset (asynchronous, any state):
  - State IDLE, cnt 0, W 0, all RK 0.
  - oBusy 0, oDone 0, oKey_Valid 0, oRound_Key 0.

## Timing
- Start edge = E0; expansion edges = E1..E7.
- oBusy is high from after E0 until after E7.
- oDone and oKey_Valid rise after E7: 7 cycles after the cycle iStart was sampled.
- RK[2k], RK[2k+1] become readable after edge Ek, for k = 1..6. RK14 becomes readable after E7.
- Read latency:
  - REG_READ=1: oRound_Key updates on the edge after iRk_Idx is presented.
  - REG_READ=0: oRound_Key updates in the same cycle as iRk_Idx.
- Back-to-back: iStart may be asserted in the cycle oDone is high; the next expansion begins at that edge.
- Critical path: one step = RotWord, S-box, then a 4-deep XOR chain per 128-bit half. There is no multicycle path.

## Structure
- Shared package aes_pkg holds: the SBOX function, RCON table (index 1..7), NUM_RK = 15, NUM_STEPS = 7, and the state enum.
- Sub-module aes256_key_step: purely combinational, inputs W[0:255] and cnt[2:0], output W'[0:255]. It instantiates 8 S-boxes.
- The controller owns the FSM, the counter, W, the 15 x 128 register file and the read mux.

## Test plan
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, iStart at E0:
  - oDone pulses after E7.
  - RK2 = 9ba35411 8e6925af a51a8b5f 2067fcde.
  - RK3 = a8b09c1a 93d194cd be49846e b75d5b9a.
  - RK14 = fe4890d1 e6188d0b 046df344 706c631e.
- Read sweep with REG_READ=1: for idx 0..15, oRound_Key matches the golden value one cycle later; idx 15 returns 0.
- iStart pulsed at E3 during EXPAND with a different iKey: the run is unaffected, oDone still arrives after E7, and the results match the first key.
- iClear at E4: oBusy drops after E4, no oDone, oKey_Valid = 0. A following iStart produces correct keys.
- Assert iRst_n low asynchronously mid-EXPAND (between edges): all outputs go to 0 immediately. After release, a new iStart completes in 7 cycles.
- Back-to-back: a second iStart with an all-zero key in the oDone cycle gives RK2 = 62636363 62636363 62636363 62636363.
